// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for APB completers
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } apb_cpl_state_t;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/apb_reg_decoder.sv
// rtl/apb_reg_decoder.sv - combinational register index and access-error decode
module apb_reg_decoder
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    NUM_REGS   = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h4000_0000,
  localparam int                   IDX_W      = $clog2(NUM_REGS)
) (
  input  logic [ADDR_WIDTH-1:0] P_ADDR,
  input  logic                  P_WRITE,
  output logic [IDX_W-1:0]      idx,
  output logic                  err
);

  // The top register is the hardware status word and cannot be written.
  localparam logic [IDX_W-1:0] STAT_IDX = IDX_W'(NUM_REGS - 1);

  logic misaligned;
  logic out_of_window;
  logic ro_write;

  // Index is the word offset inside the window; anything outside is an error.
  always_comb begin
    idx           = P_ADDR[IDX_W+1:2];
    misaligned    = (P_ADDR[1:0] != 2'b00);
    out_of_window = (P_ADDR[ADDR_WIDTH-1:IDX_W+2] != BASE_ADDR[ADDR_WIDTH-1:IDX_W+2]);
    ro_write      = P_WRITE && (idx == STAT_IDX);
    err           = misaligned || out_of_window || ro_write;
  end

endmodule

// File: rtl/apb_reg_completer.sv
// rtl/apb_reg_completer.sv - APB3 register-bank completer with wait states and error response
module apb_reg_completer
  import apb_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    NUM_REGS    = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h4000_0000,
  parameter int                    WAIT_CYCLES = 2,
  parameter logic [DATA_WIDTH-1:0] CTRL_RESET  = 32'h0000_0000
) (
  input  logic                  H_CLK,
  input  logic                  H_RESET,
  input  logic                  P_SELx,
  input  logic                  P_ENABLE,
  input  logic                  P_WRITE,
  input  logic [ADDR_WIDTH-1:0] P_ADDR,
  input  logic [DATA_WIDTH-1:0] P_WDATA,
  input  logic [DATA_WIDTH-1:0] HW_STATUS,
  output logic [DATA_WIDTH-1:0] P_RDATA,
  output logic                  P_READY,
  output logic                  P_SLVERR,
  output logic [DATA_WIDTH-1:0] CTRL_REG,
  output logic [NUM_REGS-1:0]   WR_PULSE
);

  localparam int                    IDX_W     = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0]      STAT_IDX  = IDX_W'(NUM_REGS - 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);
  localparam logic [NUM_REGS-1:0]   ONE_HOT_0 = NUM_REGS'(1);

  apb_cpl_state_t        state, state_nxt;
  logic [WAIT_CNT_W-1:0] cnt, cnt_nxt;
  logic                  capture;
  logic                  commit;

  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_err;
  logic [IDX_W-1:0]      lat_idx;
  logic                  lat_write;
  logic                  lat_err;
  logic [DATA_WIDTH-1:0] lat_wdata;

  logic [IDX_W-1:0]      cur_idx;
  logic                  cur_write;
  logic                  cur_err;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  access;

  // Status register is not stored; only control and scratch registers live here.
  logic [DATA_WIDTH-1:0] regs [NUM_REGS-1];

  apb_reg_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .BASE_ADDR  (BASE_ADDR)
  ) u_decoder (
    .P_ADDR  (P_ADDR),
    .P_WRITE (P_WRITE),
    .idx     (dec_idx),
    .err     (dec_err)
  );

  assign access   = P_SELx && P_ENABLE;
  assign CTRL_REG = regs[0];

  // Next-state logic: setup capture in IDLE, countdown in WAIT, commit at READY close.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (P_SELx && !P_ENABLE) begin
          capture   = 1'b1;
          cnt_nxt   = WAIT_LOAD;
          state_nxt = (WAIT_CYCLES == 0) ? READY : WAIT;
        end
      end
      WAIT: begin
        if (!access) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
          if (cnt == WAIT_CNT_W'(1)) begin
            state_nxt = READY;
          end
        end
      end
      READY: begin
        state_nxt = IDLE;
        commit    = access && lat_write && !lat_err;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait states READY is entered straight from the setup edge, so use live decode there.
  always_comb begin
    cur_idx   = (state == IDLE) ? dec_idx : lat_idx;
    cur_write = (state == IDLE) ? P_WRITE : lat_write;
    cur_err   = (state == IDLE) ? dec_err : lat_err;
    rd_val    = '0;
    if (cur_idx == STAT_IDX) begin
      rd_val = HW_STATUS;
    end else begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        if (cur_idx == IDX_W'(i)) begin
          rd_val = regs[i];
        end
      end
    end
  end

  // State, transfer latches and registered bus outputs.
  always_ff @(posedge H_CLK) begin
    if (H_RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_idx   <= '0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      lat_wdata <= '0;
      P_READY   <= 1'b0;
      P_SLVERR  <= 1'b0;
      P_RDATA   <= '0;
      WR_PULSE  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (capture) begin
        lat_idx   <= dec_idx;
        lat_write <= P_WRITE;
        lat_err   <= dec_err;
        lat_wdata <= P_WDATA;
      end
      P_READY  <= (state_nxt == READY);
      P_SLVERR <= (state_nxt == READY) && cur_err;
      P_RDATA  <= ((state_nxt == READY) && !cur_write && !cur_err) ? rd_val : '0;
      WR_PULSE <= commit ? (ONE_HOT_0 << lat_idx) : '0;
    end
  end

  // Register bank: a committed write updates exactly the latched index.
  always_ff @(posedge H_CLK) begin
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      if (H_RESET) begin
        regs[i] <= (i == 0) ? CTRL_RESET : '0;
      end else if (commit && (lat_idx == IDX_W'(i))) begin
        regs[i] <= lat_wdata;
      end
    end
  end

endmodule

// File: tb/tb_apb_reg_completer.sv
// tb/tb_apb_reg_completer.sv - scoreboard bench for apb_reg_completer
module tb_apb_reg_completer;

  typedef struct packed {
    logic        slverr;
    logic [31:0] rdata;
    logic [7:0]  pulse;
  } exp_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [2];
  logic        psel   [2];
  logic        pen    [2];
  logic        pwr    [2];
  logic [31:0] paddr  [2];
  logic [31:0] pwdata [2];
  logic [31:0] hw_status;
  logic [31:0] rdata  [2];
  logic [31:0] ctrl   [2];
  logic        ready  [2];
  logic        slverr [2];
  logic [7:0]  pulse  [2];

  exp_t        q0[$];
  exp_t        q1[$];
  int          vectors = 0;
  int          errors  = 0;
  bit          mon_en  = 1'b0;
  int          acc     [2] = '{0, 0};
  logic [7:0]  pend    [2] = '{8'h00, 8'h00};
  int          lat_req [2] = '{3, 1};

  apb_reg_completer #(.WAIT_CYCLES(2), .CTRL_RESET(32'h0000_0005)) u0 (
    .H_CLK(clk), .H_RESET(rst[0]), .P_SELx(psel[0]), .P_ENABLE(pen[0]),
    .P_WRITE(pwr[0]), .P_ADDR(paddr[0]), .P_WDATA(pwdata[0]), .HW_STATUS(hw_status),
    .P_RDATA(rdata[0]), .P_READY(ready[0]), .P_SLVERR(slverr[0]),
    .CTRL_REG(ctrl[0]), .WR_PULSE(pulse[0])
  );

  apb_reg_completer #(.WAIT_CYCLES(0), .CTRL_RESET(32'h0000_0000)) u1 (
    .H_CLK(clk), .H_RESET(rst[1]), .P_SELx(psel[1]), .P_ENABLE(pen[1]),
    .P_WRITE(pwr[1]), .P_ADDR(paddr[1]), .P_WDATA(pwdata[1]), .HW_STATUS(hw_status),
    .P_RDATA(rdata[1]), .P_READY(ready[1]), .P_SLVERR(slverr[1]),
    .CTRL_REG(ctrl[1]), .WR_PULSE(pulse[1])
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever a completer signals P_READY.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        exp_t e;
        chk($sformatf("wr_pulse%0d", d), 32'(pulse[d]), 32'(pend[d]));
        pend[d] = 8'h00;
        if (psel[d] && pen[d]) acc[d]++;
        else acc[d] = 0;
        if (ready[d]) begin
          if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_ready%0d: got 1 required 0", d);
          end else begin
            if (d == 0) e = q0.pop_front();
            else e = q1.pop_front();
            chk($sformatf("latency%0d", d), 32'(acc[d]), 32'(lat_req[d]));
            chk($sformatf("slverr%0d", d), 32'(slverr[d]), 32'(e.slverr));
            chk($sformatf("rdata%0d", d), rdata[d], e.rdata);
            pend[d] = e.pulse;
          end
          acc[d] = 0;
        end else begin
          chk($sformatf("idle_slverr%0d", d), 32'(slverr[d]), 32'd0);
          chk($sformatf("idle_rdata%0d", d), rdata[d], 32'd0);
        end
      end
    end
  end

  // One APB transfer; enters and leaves just after a rising edge.
  task automatic xfer(int d, bit wr, logic [31:0] a, logic [31:0] wd,
                      bit e_err, logic [31:0] e_rd, logic [7:0] e_pl);
    exp_t e;
    int   n;
    e.slverr = e_err;
    e.rdata  = e_rd;
    e.pulse  = e_pl;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
    psel[d] = 1'b1; pen[d] = 1'b0; pwr[d] = wr; paddr[d] = a; pwdata[d] = wd;
    @(posedge clk); #1;
    pen[d] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready[d]) begin
      vectors++;
      errors++;
      $display("FAIL timeout%0d: P_READY got 0 required 1", d);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(int d, int n);
    psel[d] = 1'b0;
    pen[d]  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; psel[d] = 1'b0; pen[d] = 1'b0; pwr[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0;
    end
    hw_status = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready[0]), 32'd0);
    chk("rst_slverr", 32'(slverr[0]), 32'd0);
    chk("rst_rdata", rdata[0], 32'd0);
    chk("rst_pulse", 32'(pulse[0]), 32'd0);
    chk("rst_ctrl0", ctrl[0], 32'h0000_0005);
    chk("rst_ctrl1", ctrl[1], 32'h0000_0000);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    mon_en = 1'b1;

    xfer(0, 1, 32'h4000_0004, 32'hDEAD_BEEF, 0, 32'h0, 8'b0000_0010);
    idle(0, 1);
    xfer(0, 0, 32'h4000_0004, 32'h0, 0, 32'hDEAD_BEEF, 8'h00);
    hw_status = 32'h0000_00A5;
    xfer(0, 0, 32'h4000_001C, 32'h0, 0, 32'h0000_00A5, 8'h00);
    xfer(0, 1, 32'h4000_001C, 32'h1, 1, 32'h0, 8'h00);
    xfer(0, 1, 32'h4000_0002, 32'h77, 1, 32'h0, 8'h00);
    chk("ctrl_after_misaligned", ctrl[0], 32'h0000_0005);
    xfer(0, 0, 32'h4000_0000, 32'h0, 0, 32'h0000_0005, 8'h00);
    xfer(0, 0, 32'h4000_0004, 32'h0, 0, 32'hDEAD_BEEF, 8'h00);
    xfer(0, 0, 32'h4000_0020, 32'h0, 1, 32'h0, 8'h00);
    xfer(0, 1, 32'h4000_000C, 32'h11, 0, 32'h0, 8'b0000_1000);
    xfer(0, 1, 32'h4000_000C, 32'h22, 0, 32'h0, 8'b0000_1000);
    xfer(0, 0, 32'h4000_000C, 32'h0, 0, 32'h22, 8'h00);
    idle(0, 1);

    // Reset lands in the first wait state of a write to register 2.
    psel[0] = 1'b1; pen[0] = 1'b0; pwr[0] = 1'b1;
    paddr[0] = 32'h4000_0008; pwdata[0] = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    pen[0] = 1'b1;
    rst[0] = 1'b1;
    @(posedge clk); #1;
    psel[0] = 1'b0; pen[0] = 1'b0; rst[0] = 1'b0;
    chk("abort_ready", 32'(ready[0]), 32'd0);
    chk("abort_pulse", 32'(pulse[0]), 32'd0);
    chk("abort_ctrl", ctrl[0], 32'h0000_0005);
    xfer(0, 0, 32'h4000_0008, 32'h0, 0, 32'h0, 8'h00);
    idle(0, 1);

    xfer(1, 1, 32'h4000_0000, 32'h1234, 0, 32'h0, 8'b0000_0001);
    chk("ctrl1_after_write", ctrl[1], 32'h0000_1234);
    xfer(1, 0, 32'h4000_0000, 32'h0, 0, 32'h0000_1234, 8'h00);
    idle(1, 3);
    idle(0, 1);

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
